// File: rtl/paicore_recv_2c.sv
`timescale 1ns/1ps
// paicore_recv_2c
//   Receive side of the two-channel PAICORE link. Each channel (C0, C1) takes
//   32-bit words from the chip over a 4-phase request/acknowledge handshake,
//   packs two words into a 64-bit frame (first word in [63:32]) and parks the
//   frame in a one-entry buffer. A round-robin arbiter moves buffered frames
//   into a single AXI-Stream output register toward the DMA.
//
// Ports
//   s_axis_aclk, s_axis_aresetn     clock, asynchronous active-low reset
//   recv_len                        frames per transfer (0: tlast never set)
//   data_cnt, tlast_cnt             frames in current transfer, transfers done
//   request_Cx, din_Cx              chip word valid (async) and word data
//   acknowledge_Cx                  4-phase acknowledge back to the chip
//   m_axis_tvalid/tdata/tlast/tready  AXI-Stream master
//   o_rx_done                       one-cycle pulse after the tlast handshake
//   dbg_state                       channel FSM states {C1, C0}, 1 = ACK
//
// Handshakes: on the AXIS side a frame transfers on a cycle where tvalid and
// tready are both 1; once tvalid is 1, tdata and tlast stay constant until
// that transfer. On the chip side the acknowledge rises only after a word is
// captured and falls only after the synchronised request has fallen.
module paicore_recv_2c #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,
    input  logic [31:0] recv_len,
    output logic [31:0] data_cnt,
    output logic [31:0] tlast_cnt,
    input  logic        request_C0,
    input  logic [31:0] din_C0,
    output logic        acknowledge_C0,
    input  logic        request_C1,
    input  logic [31:0] din_C1,
    output logic        acknowledge_C1,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        o_rx_done,
    output logic [1:0]  dbg_state
);

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_ACK  = 1'b1
    } ch_state_t;

    ch_state_t              state_q [2];
    ch_state_t              state_d [2];
    logic [SYNC_STAGES-1:0] sync_q  [2];
    logic [63:0]            hold_q  [2];
    logic [63:0]            buf_q   [2];
    logic [31:0]            din_w   [2];
    logic [1:0]             req_raw;
    logic [1:0]             req_s;
    logic [1:0]             capture;
    logic [1:0]             phase_q;   // 0: next capture is the first word
    logic [1:0]             pend_q;    // second word captured last cycle
    logic [1:0]             buf_v_q;
    logic [1:0]             grant_clr;

    logic        prio_q;               // channel favoured when both are valid
    logic        hs;
    logic        out_free;
    logic        load;
    logic        load_sel;
    logic        load_last;
    logic [31:0] load_idx;

    assign req_raw   = {request_C1, request_C0};
    assign din_w[0]  = din_C0;
    assign din_w[1]  = din_C1;
    assign req_s[0]  = sync_q[0][SYNC_STAGES-1];
    assign req_s[1]  = sync_q[1][SYNC_STAGES-1];

    assign acknowledge_C0 = (state_q[0] == CH_ACK);
    assign acknowledge_C1 = (state_q[1] == CH_ACK);
    assign dbg_state      = {state_q[1], state_q[0]};

    // Channel FSMs: a word is taken only from IDLE, so a request held high
    // past the acknowledge can never be captured twice.
    always_comb begin
        capture = 2'b00;
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                CH_IDLE: begin
                    if (req_s[c] && !buf_v_q[c]) begin
                        capture[c] = 1'b1;
                        state_d[c] = CH_ACK;
                    end
                end
                CH_ACK: begin
                    if (!req_s[c]) begin
                        state_d[c] = CH_IDLE;
                    end
                end
                default: state_d[c] = CH_IDLE;
            endcase
        end
    end

    // Arbiter. The index of the frame being loaded accounts for the frame
    // leaving the output register in this same cycle.
    always_comb begin
        hs        = m_axis_tvalid & m_axis_tready;
        out_free  = !m_axis_tvalid || m_axis_tready;
        load      = out_free && (buf_v_q != 2'b00);
        load_sel  = (buf_v_q == 2'b11) ? prio_q : buf_v_q[1];
        grant_clr = load ? (2'b01 << load_sel) : 2'b00;
        if (hs) begin
            load_idx = m_axis_tlast ? 32'd0 : data_cnt + 32'd1;
        end else begin
            load_idx = data_cnt;
        end
        load_last = (recv_len != 32'd0) && (load_idx == recv_len - 32'd1);
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= CH_IDLE;
                sync_q[c]  <= '0;
                hold_q[c]  <= '0;
                buf_q[c]   <= '0;
            end
            phase_q <= 2'b00;
            pend_q  <= 2'b00;
            buf_v_q <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                sync_q[c]  <= {sync_q[c][SYNC_STAGES-2:0], req_raw[c]};
                state_q[c] <= state_d[c];
                if (capture[c]) begin
                    if (!phase_q[c]) begin
                        hold_q[c][63:32] <= din_w[c];
                    end else begin
                        hold_q[c][31:0] <= din_w[c];
                    end
                    phase_q[c] <= ~phase_q[c];
                end
                pend_q[c] <= capture[c] & phase_q[c];
                if (pend_q[c]) begin
                    buf_q[c] <= hold_q[c];
                end
                // A set needs an empty buffer, so set and clear never collide.
                if (grant_clr[c]) begin
                    buf_v_q[c] <= 1'b0;
                end else if (pend_q[c]) begin
                    buf_v_q[c] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            prio_q        <= 1'b0;
            data_cnt      <= '0;
            tlast_cnt     <= '0;
            o_rx_done     <= 1'b0;
        end else begin
            o_rx_done <= hs & m_axis_tlast;
            if (hs) begin
                if (m_axis_tlast) begin
                    data_cnt  <= '0;
                    tlast_cnt <= tlast_cnt + 32'd1;
                end else begin
                    data_cnt  <= data_cnt + 32'd1;
                end
            end
            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= buf_q[load_sel];
                m_axis_tlast  <= load_last;
                prio_q        <= ~load_sel;
            end else if (hs) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_paicore_recv_2c.sv
`timescale 1ns/1ps
module tb_paicore_recv_2c;

  localparam int SYNC = 2;

  logic        clk;
  logic        s_axis_aresetn;
  logic [31:0] recv_len;
  logic [31:0] data_cnt;
  logic [31:0] tlast_cnt;
  logic        request_C0;
  logic [31:0] din_C0;
  logic        acknowledge_C0;
  logic        request_C1;
  logic [31:0] din_C1;
  logic        acknowledge_C1;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        o_rx_done;
  logic [1:0]  dbg_state;

  paicore_recv_2c #(.SYNC_STAGES(SYNC)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (s_axis_aresetn),
    .recv_len       (recv_len),
    .data_cnt       (data_cnt),
    .tlast_cnt      (tlast_cnt),
    .request_C0     (request_C0),
    .din_C0         (din_C0),
    .acknowledge_C0 (acknowledge_C0),
    .request_C1     (request_C1),
    .din_C1         (din_C1),
    .acknowledge_C1 (acknowledge_C1),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .o_rx_done      (o_rx_done),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  int          src_log[$];
  int          words_acked[2];
  int          done_cnt = 0;
  logic [31:0] model_cnt = 0;
  logic        prev_last_hs = 0;
  logic        prev_stall = 0;
  logic [63:0] prev_data = 0;
  logic        prev_last = 0;
  logic [63:0] last_tdata = 0;
  logic        last_tlast = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic exp_last;
    if (!s_axis_aresetn) begin
      model_cnt    = 0;
      prev_last_hs = 0;
      prev_stall   = 0;
    end else begin
      check("rx_done", {63'd0, o_rx_done}, {63'd0, prev_last_hs});
      if (o_rx_done) done_cnt++;
      if (prev_stall) begin
        check("hold_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check("hold_tdata", m_axis_tdata, prev_data);
        check("hold_tlast", {63'd0, m_axis_tlast}, {63'd0, prev_last});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        exp_last = (recv_len != 0) && (model_cnt == recv_len - 1);
        check("tlast", {63'd0, m_axis_tlast}, {63'd0, exp_last});
        model_cnt = exp_last ? 32'd0 : model_cnt + 32'd1;
        n_cmp++;
        if (exp_q0.size() > 0 && exp_q0[0] == m_axis_tdata) begin
          src_log.push_back(0);
          void'(exp_q0.pop_front());
        end else if (exp_q1.size() > 0 && exp_q1[0] == m_axis_tdata) begin
          src_log.push_back(1);
          void'(exp_q1.pop_front());
        end else begin
          n_fail++;
          $display("FAIL frame_data: got 0x%0h, expected head of a channel queue (c0 %0d left, c1 %0d left)",
                   m_axis_tdata, exp_q0.size(), exp_q1.size());
        end
        last_tdata = m_axis_tdata;
        last_tlast = m_axis_tlast;
      end
      prev_last_hs = m_axis_tvalid & m_axis_tready & m_axis_tlast;
      prev_stall   = m_axis_tvalid & !m_axis_tready;
      prev_data    = m_axis_tdata;
      prev_last    = m_axis_tlast;
    end
  end

  // ---------------- chip-side driver ----------------
  function automatic logic ack_of(input int ch);
    return (ch == 0) ? acknowledge_C0 : acknowledge_C1;
  endfunction

  task automatic set_req(input int ch, input logic r, input logic [31:0] w);
    if (ch == 0) begin
      din_C0 = w; request_C0 = r;
    end else begin
      din_C1 = w; request_C1 = r;
    end
  endtask

  task automatic send_word(input int ch, input logic [31:0] w, input int bound);
    int n;
    @(posedge clk); #1;
    set_req(ch, 1'b1, w);
    n = 0;
    while (!ack_of(ch) && n < bound) begin
      @(posedge clk); #1; n++;
    end
    if (!ack_of(ch)) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_rise_timeout: ch %0d got no ack, expected ack within %0d clk", ch, bound);
    end else begin
      words_acked[ch]++;
    end
    set_req(ch, 1'b0, w);
    n = 0;
    while (ack_of(ch) && n < bound) begin
      @(posedge clk); #1; n++;
    end
    if (ack_of(ch)) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_fall_timeout: ch %0d ack still 1, expected 0 within %0d clk", ch, bound);
    end
  endtask

  task automatic send_seq(input int ch, input logic [31:0] base, input int n, input int bound);
    for (int i = 1; i <= n; i++) send_word(ch, base + i, bound);
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && n < bound) begin
      @(negedge clk); n++;
    end
    if ((exp_q0.size() + exp_q1.size()) != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d frames outstanding, expected 0", exp_q0.size() + exp_q1.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] len;
    int          ch;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp_data;
    logic        exp_last;
    logic [31:0] exp_dcnt;
    logic [31:0] exp_tcnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n;
    int acked0;
    vecs[0] = '{32'd1, 0, 32'hAAAA0001, 32'hBBBB0002, 64'hAAAA0001BBBB0002, 1'b1, 32'd0, 32'd1};
    vecs[1] = '{32'd2, 1, 32'h11111111, 32'h22222222, 64'h1111111122222222, 1'b0, 32'd1, 32'd1};
    vecs[2] = '{32'd2, 0, 32'h33333333, 32'h44444444, 64'h3333333344444444, 1'b1, 32'd0, 32'd2};
    vecs[3] = '{32'd0, 1, 32'hDEADBEEF, 32'h01234567, 64'hDEADBEEF01234567, 1'b0, 32'd1, 32'd2};
    vecs[4] = '{32'd0, 0, 32'hCAFEF00D, 32'h0000FFFF, 64'hCAFEF00D0000FFFF, 1'b0, 32'd2, 32'd2};
    vecs[5] = '{32'd0, 1, 32'hFFFFFFFF, 32'h00000000, 64'hFFFFFFFF00000000, 1'b0, 32'd3, 32'd2};
    vecs[6] = '{32'd4, 0, 32'h5A5A5A5A, 32'hA5A5A5A5, 64'h5A5A5A5AA5A5A5A5, 1'b1, 32'd0, 32'd3};
    vecs[7] = '{32'd1, 1, 32'h89ABCDEF, 32'h76543210, 64'h89ABCDEF76543210, 1'b1, 32'd0, 32'd4};

    // ---- reset ----
    s_axis_aresetn = 1'b0;
    recv_len = 0; m_axis_tready = 1'b0;
    request_C0 = 1'b0; din_C0 = 0; request_C1 = 1'b0; din_C1 = 0;
    words_acked[0] = 0; words_acked[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    check("rst_ack0", {63'd0, acknowledge_C0}, 64'd0);
    check("rst_ack1", {63'd0, acknowledge_C1}, 64'd0);
    check("rst_data_cnt", {32'd0, data_cnt}, 64'd0);
    check("rst_tlast_cnt", {32'd0, tlast_cnt}, 64'd0);
    check("rst_rx_done", {63'd0, o_rx_done}, 64'd0);
    s_axis_aresetn = 1'b1;
    repeat (2) @(posedge clk);

    // ---- single frames from the table ----
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      recv_len = vecs[i].len;
      if (vecs[i].ch == 0) exp_q0.push_back(vecs[i].exp_data);
      else exp_q1.push_back(vecs[i].exp_data);
      send_word(vecs[i].ch, vecs[i].w0, 50);
      send_word(vecs[i].ch, vecs[i].w1, 50);
      wait_drain(50);
      check($sformatf("vec%0d_tdata", i), last_tdata, vecs[i].exp_data);
      check($sformatf("vec%0d_tlast", i), {63'd0, last_tlast}, {63'd0, vecs[i].exp_last});
      check($sformatf("vec%0d_data_cnt", i), {32'd0, data_cnt}, {32'd0, vecs[i].exp_dcnt});
      check($sformatf("vec%0d_tlast_cnt", i), {32'd0, tlast_cnt}, {32'd0, vecs[i].exp_tcnt});
      check($sformatf("vec%0d_done_cnt", i), done_cnt, {32'd0, vecs[i].exp_tcnt});
    end

    // ---- both channels, 4 words each, raised together ----
    recv_len = 4;
    src_log.delete();
    exp_q0.push_back(64'h0A0000010A000002); exp_q0.push_back(64'h0A0000030A000004);
    exp_q1.push_back(64'h1B0000011B000002); exp_q1.push_back(64'h1B0000031B000004);
    fork
      send_seq(0, 32'h0A000000, 4, 50);
      send_seq(1, 32'h1B000000, 4, 50);
    join
    wait_drain(50);
    check("rr_frames", src_log.size(), 64'd4);
    for (int i = 0; i < 4 && i < src_log.size(); i++)
      check($sformatf("rr_order%0d", i), src_log[i], (i % 2 == 0) ? 64'd0 : 64'd1);
    check("rr_data_cnt", {32'd0, data_cnt}, 64'd0);
    check("rr_tlast_cnt", {32'd0, tlast_cnt}, 64'd5);
    check("rr_done_cnt", done_cnt, 64'd5);

    // ---- output stalled, 6 words each ----
    recv_len = 0;
    m_axis_tready = 1'b0;
    acked0 = words_acked[0] + words_acked[1];
    exp_q0.push_back(64'hC0000001C0000002); exp_q0.push_back(64'hC0000003C0000004);
    exp_q0.push_back(64'hC0000005C0000006);
    exp_q1.push_back(64'hC1000001C1000002); exp_q1.push_back(64'hC1000003C1000004);
    exp_q1.push_back(64'hC1000005C1000006);
    fork
      send_seq(0, 32'hC0000000, 6, 300);
      send_seq(1, 32'hC1000000, 6, 300);
      begin
        repeat (50) @(posedge clk);
        #1;
        // Output register + one buffer per channel: three frames absorbed.
        check("stall_words_acked", words_acked[0] + words_acked[1] - acked0, 64'd6);
        check("stall_ack0", {63'd0, acknowledge_C0}, 64'd0);
        check("stall_ack1", {63'd0, acknowledge_C1}, 64'd0);
        check("stall_req0", {63'd0, request_C0}, 64'd1);
        check("stall_req1", {63'd0, request_C1}, 64'd1);
        check("stall_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check("stall_tdata", m_axis_tdata, 64'hC0000001C0000002);
        check("stall_data_cnt", {32'd0, data_cnt}, 64'd0);
        m_axis_tready = 1'b1;
      end
    join
    wait_drain(100);
    check("stall_data_cnt_end", {32'd0, data_cnt}, 64'd6);

    // ---- request held high long after ack ----
    exp_q0.push_back(64'h12345678ABCDEF01);
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h12345678);
    n = 0;
    while (!acknowledge_C0 && n < 20) begin @(posedge clk); #1; n++; end
    check("lat_ack_rise", n, SYNC + 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (acknowledge_C0) n++;
    end
    check("ack_held", n, 64'd20);
    check("held_no_output", {63'd0, m_axis_tvalid}, 64'd0);
    set_req(0, 1'b0, 32'h12345678);
    n = 0;
    while (acknowledge_C0 && n < 20) begin @(posedge clk); #1; n++; end
    check("lat_ack_fall", n, SYNC + 1);
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'hABCDEF01);
    n = 0;
    while (!acknowledge_C0 && n < 20) begin @(posedge clk); #1; n++; end
    check("lat_ack_rise2", n, SYNC + 1);
    n = 0;
    while (!m_axis_tvalid && n < 20) begin @(posedge clk); #1; n++; end
    check("lat_capture_to_tvalid", n, 64'd2);
    set_req(0, 1'b0, 32'hABCDEF01);
    n = 0;
    while (acknowledge_C0 && n < 20) begin @(posedge clk); #1; n++; end
    wait_drain(50);
    check("held_data_cnt", {32'd0, data_cnt}, 64'd7);

    // ---- reset after the first word of a C1 frame ----
    recv_len = 1;
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'hBAD0BAD0);
    n = 0;
    while (!acknowledge_C1 && n < 20) begin @(posedge clk); #1; n++; end
    check("pre_rst_ack1", {63'd0, acknowledge_C1}, 64'd1);
    s_axis_aresetn = 1'b0;
    #1;
    check("rst_ack1_async", {63'd0, acknowledge_C1}, 64'd0);
    set_req(1, 1'b0, 32'hBAD0BAD0);
    repeat (3) @(posedge clk);
    #1;
    s_axis_aresetn = 1'b1;
    check("mid_rst_tlast_cnt", {32'd0, tlast_cnt}, 64'd0);
    check("mid_rst_data_cnt", {32'd0, data_cnt}, 64'd0);
    exp_q1.push_back(64'h600D0001600D0002);
    send_word(1, 32'h600D0001, 50);
    send_word(1, 32'h600D0002, 50);
    wait_drain(50);
    check("post_rst_tdata", last_tdata, 64'h600D0001600D0002);
    check("post_rst_tlast", {63'd0, last_tlast}, 64'd1);
    check("post_rst_tlast_cnt", {32'd0, tlast_cnt}, 64'd1);
    check("end_queues_empty", exp_q0.size() + exp_q1.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
